// File: rtl/hazard_ctrl_if.sv
// Hazard-code and pipeline-control bundle between the ID-stage detectors/datapath
// (master) and the hazard controller (slave).
interface hazard_ctrl_if #(parameter int CNT_W = 16);
    logic [5:0]       hz_d1;
    logic [5:0]       hz_d2;
    logic             id_valid;
    logic             rs_zero;
    logic             rt_zero;
    logic             br_taken_e;
    logic             mem_hold;
    logic             pc_en;
    logic             ifid_en;
    logic             ifid_flush;
    logic             idex_flush;
    logic [1:0]       fwd_a_e;
    logic [1:0]       fwd_b_e;
    logic             stall_st;
    logic [CNT_W-1:0] stall_cnt;

    modport master (
        output hz_d1, hz_d2, id_valid, rs_zero, rt_zero, br_taken_e, mem_hold,
        input  pc_en, ifid_en, ifid_flush, idex_flush, fwd_a_e, fwd_b_e,
               stall_st, stall_cnt
    );

    modport slave (
        input  hz_d1, hz_d2, id_valid, rs_zero, rt_zero, br_taken_e, mem_hold,
        output pc_en, ifid_en, ifid_flush, idex_flush, fwd_a_e, fwd_b_e,
               stall_st, stall_cnt
    );
endinterface

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: load-use single-bubble stall, branch flush, memory
// freeze, registered EX forwarding selects and a saturating stall counter.
module hazard_ctrl #(
    parameter int CNT_W = 16
) (
    input logic        clk,
    input logic        rst_n,
    hazard_ctrl_if.slave hz
);
    typedef enum logic {IDLE, STALL} stateT;

    localparam logic [5:0] LOAD_USE = 6'b111111;
    localparam logic [1:0] SRC_RF   = 2'b00;
    localparam logic [1:0] SRC_EXM  = 2'b01;
    localparam logic [1:0] SRC_MWB  = 2'b10;

    stateT            state;
    logic [1:0]       fwdA;
    logic [1:0]       fwdB;
    logic [CNT_W-1:0] stallCnt;
    logic             loadUse;

    // Register $zero never forwards; distance 1 outranks distance 2, and only the
    // one meaningful code per distance is honoured.
    function automatic logic [1:0] pickSrc(input logic isZero, input logic [1:0] d1Field,
                                           input logic [1:0] d2Field, input logic useD1);
        if (isZero)                          return SRC_RF;
        if (useD1 && d1Field == SRC_EXM)     return SRC_EXM;
        if (d2Field == SRC_MWB)              return SRC_MWB;
        return SRC_RF;
    endfunction

    assign loadUse = (state == IDLE) && hz.id_valid && (hz.hz_d1 == LOAD_USE);

    always_comb begin
        // NOTE: every output gets a default first so no path through the
        // branches below can leave one unassigned and infer a latch.
        hz.pc_en      = 1'b0;
        hz.ifid_en    = 1'b0;
        hz.ifid_flush = 1'b0;
        hz.idex_flush = 1'b0;
        if (rst_n && !hz.mem_hold) begin
            if (hz.br_taken_e) begin
                hz.pc_en      = 1'b1;
                hz.ifid_en    = 1'b1;
                hz.ifid_flush = 1'b1;
                hz.idex_flush = 1'b1;
            end else if (loadUse) begin
                hz.idex_flush = 1'b1;
            end else begin
                hz.pc_en   = 1'b1;
                hz.ifid_en = 1'b1;
            end
        end
    end

    // NOTE: state is updated with non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            fwdA     <= SRC_RF;
            fwdB     <= SRC_RF;
            stallCnt <= '0;
        end else if (!hz.mem_hold) begin
            if (hz.br_taken_e || !hz.id_valid) begin
                state <= IDLE;
                fwdA  <= SRC_RF;
                fwdB  <= SRC_RF;
            end else if (loadUse) begin
                state <= STALL;
                fwdA  <= SRC_RF;
                fwdB  <= SRC_RF;
                if (stallCnt != '1) stallCnt <= stallCnt + CNT_W'(1);
            end else if (state == STALL) begin
                // EX holds the bubble, so the distance-1 code is stale here.
                state <= IDLE;
                fwdA  <= pickSrc(hz.rs_zero, hz.hz_d1[3:2], hz.hz_d2[3:2], 1'b0);
                fwdB  <= pickSrc(hz.rt_zero, hz.hz_d1[1:0], hz.hz_d2[1:0], 1'b0);
            end else begin
                fwdA <= pickSrc(hz.rs_zero, hz.hz_d1[3:2], hz.hz_d2[3:2], 1'b1);
                fwdB <= pickSrc(hz.rt_zero, hz.hz_d1[1:0], hz.hz_d2[1:0], 1'b1);
            end
        end
    end

    assign hz.fwd_a_e   = fwdA;
    assign hz.fwd_b_e   = fwdB;
    assign hz.stall_st  = (state == STALL);
    assign hz.stall_cnt = stallCnt;
endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl: a cycle-level model of the control rules is
// compared every cycle, with literal expectations pinning the model.
module tb_hazard_ctrl;
    localparam int CNT_W   = 3;
    localparam int CNT_MAX = (1 << CNT_W) - 1;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   errors = 0;
    int   checks = 0;

    // Model state: pending stall, forwarding selects visible in EX, stall count.
    bit   mStall;
    int   mFwdA;
    int   mFwdB;
    int   mCnt;

    hazard_ctrl_if #(.CNT_W(CNT_W)) bus ();

    hazard_ctrl #(.CNT_W(CNT_W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .hz    (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Operand source from the hazard rules: 0 regfile, 1 EX/MEM, 2 MEM/WB.
    function automatic int srcOf(input bit zero, input int f1, input int f2, input bit d1Ok);
        int src = 0;
        if (!zero) begin
            if (d1Ok && f1 == 1) src = 1;
            else if (f2 == 2)    src = 2;
        end
        return src;
    endfunction

    // Drive one cycle of inputs, compare mid-cycle against the model, then advance it.
    task automatic step(input logic [5:0] d1, input logic [5:0] d2, input bit idv,
                        input bit rsz, input bit rtz, input bit br, input bit hold);
        int ePc, eFlIf, eFlEx;
        bit lu;
        @(posedge clk);
        #1;
        bus.hz_d1 = d1; bus.hz_d2 = d2; bus.id_valid = idv;
        bus.rs_zero = rsz; bus.rt_zero = rtz; bus.br_taken_e = br; bus.mem_hold = hold;
        @(negedge clk);
        if (!rst_n) begin
            mStall = 0; mFwdA = 0; mFwdB = 0; mCnt = 0;
        end
        lu = rst_n && !hold && !br && !mStall && idv && (d1 == 6'h3f);
        ePc   = (rst_n && !hold && !lu) ? 1 : 0;
        eFlIf = (rst_n && !hold && br) ? 1 : 0;
        eFlEx = (rst_n && !hold && (br || lu)) ? 1 : 0;
        check("pc_en",      int'(bus.pc_en),      ePc);
        check("ifid_en",    int'(bus.ifid_en),    ePc);
        check("ifid_flush", int'(bus.ifid_flush), eFlIf);
        check("idex_flush", int'(bus.idex_flush), eFlEx);
        check("fwd_a_e",    int'(bus.fwd_a_e),    mFwdA);
        check("fwd_b_e",    int'(bus.fwd_b_e),    mFwdB);
        check("stall_st",   int'(bus.stall_st),   int'(mStall));
        check("stall_cnt",  int'(bus.stall_cnt),  mCnt);
        if (rst_n && !hold) begin
            if (br || !idv) begin
                mStall = 0; mFwdA = 0; mFwdB = 0;
            end else if (lu) begin
                mStall = 1; mFwdA = 0; mFwdB = 0;
                if (mCnt < CNT_MAX) mCnt++;
            end else begin
                mFwdA = srcOf(rsz, int'(d1[3:2]), int'(d2[3:2]), !mStall);
                mFwdB = srcOf(rtz, int'(d1[1:0]), int'(d2[1:0]), !mStall);
                mStall = 0;
            end
        end
    endtask

    initial begin
        mStall = 0; mFwdA = 0; mFwdB = 0; mCnt = 0;
        bus.hz_d1 = '0; bus.hz_d2 = '0; bus.id_valid = 1'b1; bus.rs_zero = 1'b0;
        bus.rt_zero = 1'b0; bus.br_taken_e = 1'b0; bus.mem_hold = 1'b0;

        // Reset, then release with clean codes.
        step(6'h00, 6'h00, 1, 0, 0, 0, 0);
        check("rst_pc_en", int'(bus.pc_en), 0);
        step(6'h00, 6'h00, 1, 0, 0, 0, 0);
        rst_n = 1'b1;
        step(6'h00, 6'h00, 1, 0, 0, 0, 0);
        check("lit_pc_en_after_rst", int'(bus.pc_en), 1);
        check("lit_cnt_after_rst", int'(bus.stall_cnt), 0);

        // Distance 1 beats distance 2 on both operands.
        step(6'b000101, 6'b001010, 1, 0, 0, 0, 0);
        step(6'h00, 6'h00, 1, 0, 0, 0, 0);
        check("lit_d1_wins_a", int'(bus.fwd_a_e), 1);
        check("lit_d1_wins_b", int'(bus.fwd_b_e), 1);

        // Load-use then stall cycle with A forwarded from MEM/WB.
        step(6'h3f, 6'h00, 1, 0, 0, 0, 0);
        check("lit_lu_pc_en", int'(bus.pc_en), 0);
        check("lit_lu_idex_flush", int'(bus.idex_flush), 1);
        step(6'h3f, 6'b001000, 1, 0, 0, 0, 0);
        check("lit_stall_pc_en", int'(bus.pc_en), 1);
        check("lit_stall_st", int'(bus.stall_st), 1);
        check("lit_stall_cnt1", int'(bus.stall_cnt), 1);
        step(6'h00, 6'h00, 1, 0, 0, 0, 0);
        check("lit_stall_fwd_a", int'(bus.fwd_a_e), 2);
        check("lit_stall_done", int'(bus.stall_st), 0);

        // Load-use coincident with a taken branch: flush, no stall.
        step(6'h3f, 6'h00, 1, 0, 0, 1, 0);
        check("lit_br_ifid_flush", int'(bus.ifid_flush), 1);
        check("lit_br_pc_en", int'(bus.pc_en), 1);
        step(6'h00, 6'h00, 1, 0, 0, 0, 0);
        check("lit_br_no_stall", int'(bus.stall_st), 0);
        check("lit_br_cnt", int'(bus.stall_cnt), 1);

        // Memory hold for three cycles inside STALL; repeat load-use code never re-stalls.
        step(6'h3f, 6'h00, 1, 0, 0, 0, 0);
        for (int i = 0; i < 3; i++) step(6'h3f, 6'b001000, 1, 0, 0, 0, 1);
        check("lit_hold_pc_en", int'(bus.pc_en), 0);
        check("lit_hold_stall", int'(bus.stall_st), 1);
        step(6'h3f, 6'b000010, 1, 0, 0, 0, 0);
        check("lit_after_hold_pc_en", int'(bus.pc_en), 1);
        step(6'h00, 6'h00, 1, 0, 0, 0, 0);
        check("lit_after_hold_fwd_b", int'(bus.fwd_b_e), 2);
        check("lit_after_hold_idle", int'(bus.stall_st), 0);

        // Zero registers, invalid ID, and meaningless field codes.
        step(6'b000100, 6'h00, 1, 1, 0, 0, 0);
        step(6'b000100, 6'h00, 1, 0, 0, 0, 0);
        check("lit_rs_zero", int'(bus.fwd_a_e), 0);
        step(6'b000101, 6'b001010, 0, 0, 0, 0, 0);
        check("lit_d1_a", int'(bus.fwd_a_e), 1);
        step(6'b001000, 6'b000001, 1, 0, 0, 0, 0);
        check("lit_invalid_id", int'(bus.fwd_b_e), 0);
        step(6'b001010, 6'b001010, 1, 0, 1, 0, 0);
        step(6'h3f, 6'h00, 0, 0, 0, 0, 0);
        check("lit_d2_a_rt_zero", int'(bus.fwd_a_e) * 4 + int'(bus.fwd_b_e), 8);

        // Reset asserted mid-STALL leaves no pending bubble.
        step(6'h3f, 6'h00, 1, 0, 0, 0, 0);
        rst_n = 1'b0;
        step(6'h00, 6'h00, 1, 0, 0, 0, 0);
        check("lit_rst_mid_stall", int'(bus.stall_st), 0);
        rst_n = 1'b1;
        step(6'h00, 6'h00, 1, 0, 0, 0, 0);
        check("lit_no_bubble_after_rst", int'(bus.pc_en), 1);

        // Saturate the stall counter.
        for (int i = 0; i < CNT_MAX + 2; i++) begin
            step(6'h3f, 6'h00, 1, 0, 0, 0, 0);
            step(6'h00, 6'h00, 1, 0, 0, 0, 0);
        end
        step(6'h00, 6'h00, 1, 0, 0, 0, 0);
        check("lit_cnt_saturated", int'(bus.stall_cnt), CNT_MAX);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/hazard_ctrl.md
Name: hazard_ctrl

Overview:
- Pipeline hazard controller; the consumer side of the hazard-code interface driven by the ID-stage dependency detectors.
- Takes 6-bit hazard codes for distance 1 (ID vs EX) and distance 2 (ID vs MEM).
- Generates PC/IF-ID enables, IF-ID and ID-EX flush/bubble controls, and registered EX-stage forwarding mux selects.
- Sits between the detectors and the datapath pipeline registers.
- Owns the load-use single-bubble stall sequence and a stall statistics counter.

Parameters:
CNT_W, 16, width of saturating stall counter

Ports:
clk  in  1  rising-edge clock
rst_n  in  1  asynchronous active-low reset
hz_d1  in  6  distance-1 hazard code
hz_d2  in  6  distance-2 hazard code
id_valid  in  1  ID stage holds a real instruction
rs_zero  in  1  ID rs field == 0
rt_zero  in  1  ID rt field == 0
br_taken_e  in  1  branch resolved taken in EX
mem_hold  in  1  memory wait, freeze pipeline
pc_en  out  1  PC write enable
ifid_en  out  1  IF/ID register enable
ifid_flush  out  1  IF/ID clear to NOP
idex_flush  out  1  ID/EX clear to NOP (bubble)
fwd_a_e  out  2  EX operand-A source: 00 regfile, 01 EX/MEM, 10 MEM/WB
fwd_b_e  out  2  EX operand-B source, same encoding
stall_st  out  1  1 while FSM is in STALL
stall_cnt  out  CNT_W  load-use stalls taken, saturating

Behaviour:
- Hazard code format:
  - bit5: operand-A load-use. bit4: operand-B load-use.
  - [3:2]: A forward field. [1:0]: B forward field.
  - 6'b111111 = load-use.
- Only 01 is meaningful in a hz_d1 field; only 10 in a hz_d2 field. Any other field value is treated as 00.
- Clocking: one clock; reset is asynchronous and active-low.
- Reset (rst_n low):
  - FSM = IDLE; fwd_a_e = fwd_b_e = 00; stall_cnt = 0.
  - pc_en = ifid_en = 0; ifid_flush = idex_flush = 0.
- FSM states: IDLE, STALL. Control outputs are combinational from state and inputs. fwd_*_e and stall_cnt are registered.
- Per-cycle precedence: mem_hold > br_taken_e > load-use > normal.
- mem_hold = 1:
  - pc_en = ifid_en = 0; both flushes = 0.
  - FSM, fwd_*_e and stall_cnt all hold.
- br_taken_e = 1 (no hold):
  - pc_en = ifid_en = 1; ifid_flush = idex_flush = 1.
  - fwd_*_e <= 00; FSM <= IDLE. Also aborts a pending STALL.
- Load-use (IDLE, id_valid = 1, hz_d1 == 6'b111111):
  - pc_en = ifid_en = 0; idex_flush = 1.
  - fwd_*_e <= 00; FSM <= STALL; stall_cnt += 1, saturating at all-ones.
- STALL state (no hold/branch):
  - pc_en = ifid_en = 1. hz_d1 is ignored entirely, because EX holds the bubble.
  - fwd_a_e <= rs_zero ? 00 : (hz_d2[3:2] == 10 ? 10 : 00); fwd_b_e likewise from rt_zero and hz_d2[1:0].
  - FSM <= IDLE.
  - Exactly one bubble per load-use; a second consecutive 111111 in STALL never re-stalls.
- Normal (IDLE, no load-use):
  - pc_en = ifid_en = 1; flushes = 0.
  - fwd_a_e <= rs_zero ? 00 : hz_d1[3:2] == 01 ? 01 : hz_d2[3:2] == 10 ? 10 : 00. Distance 1 has priority.
  - fwd_b_e likewise using rt_zero and the [1:0] fields.
- id_valid = 0: codes ignored; fwd_*_e <= 00; no stall.
- Latency: fwd_*_e are valid one cycle after ID sampling, aligned with the instruction in EX.
- Reset asserted mid-STALL: returns to IDLE immediately; no pending bubble on release.

Test Plan:
- Reset then release with hz_d1 = hz_d2 = 0, id_valid = 1 -> pc_en = 1, fwd_a_e = fwd_b_e = 00, stall_cnt = 0.
- hz_d1 = 6'b000101, hz_d2 = 6'b001010 -> next cycle fwd_a_e = 01, fwd_b_e = 01 (distance 1 wins on both).
- hz_d1 = 6'b111111 held two cycles, hz_d2 = 6'b001000 in cycle 2 -> cycle 1: pc_en = 0, idex_flush = 1; cycle 2: pc_en = 1, stall_st = 1, fwd_a_e <= 10; stall_cnt = 1.
- Load-use coincident with br_taken_e = 1 -> ifid_flush = idex_flush = 1, pc_en = 1, no STALL, stall_cnt unchanged.
- mem_hold = 1 during STALL for 3 cycles -> pc_en = 0, state and fwd held; STALL completes on the first cycle after hold drops.
- rs_zero = 1 with hz_d1 = 6'b000100 -> fwd_a_e = 00. Force stall_cnt to all-ones then trigger a load-use -> stall_cnt stays all-ones.
